// File: rtl/apb_cmd_master.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer and returns a response.
// Latency: 4 cycles per transfer with a zero-wait slave (handshake, SETUP, ACCESS, RESP), +1 per wait state.
// Backpressure: one transfer in flight; cmd_ready low until the response is consumed, response held while rsp_ready low.

package apb_cmd_master_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;
endpackage

module apb_cmd_master #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 16,
    parameter type         req_t         = apb_cmd_master_pkg::apb_req_t,
    parameter type         resp_t        = apb_cmd_master_pkg::apb_resp_t,
    parameter int unsigned StrbWidth     = DataWidth / 8
) (
    input  logic                 pclk_i,
    input  logic                 preset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic                 cmd_write_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    input  logic [StrbWidth-1:0] cmd_strb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output req_t                 apb_req_o,
    input  resp_t                apb_resp_i
);

    // Wait counter is wide enough to hold TimeoutCycles; at least one bit when the timeout is disabled.
    localparam int unsigned CntWidth = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [AddrWidth-1:0]   paddr_q;
    logic                   pwrite_q;
    logic [DataWidth-1:0]   pwdata_q;
    logic [StrbWidth-1:0]   pstrb_q;
    logic                   psel_q;
    logic                   penable_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic                   rsp_timeout_q;
    logic [DataWidth-1:0]   rsp_rdata_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [CntWidth-1:0]    cnt_inc;

    // Saturating increment so a disabled or very long timeout never wraps the counter.
    assign cnt_inc = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    assign cmd_ready_o   = (state_q == IDLE) && !preset_i;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

    // Pack the registered request fields onto the APB request bus.
    always_comb begin
        apb_req_o         = '0;
        apb_req_o.paddr   = paddr_q;
        apb_req_o.psel    = psel_q;
        apb_req_o.penable = penable_q;
        apb_req_o.pwrite  = pwrite_q;
        apb_req_o.pwdata  = pwdata_q;
        apb_req_o.pstrb   = pstrb_q;
    end

    // Transfer sequencer: all APB and response outputs are registered here.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        paddr_q  <= cmd_addr_i;
                        pwrite_q <= cmd_write_i;
                        // Reads never drive data or strobes onto the bus.
                        pwdata_q <= cmd_write_i ? cmd_wdata_i : '0;
                        pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
                        psel_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A completion in the same cycle as the limit wins over the timeout.
                    if (apb_resp_i.pready) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : apb_resp_i.prdata;
                        rsp_err_q     <= apb_resp_i.pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                        if ((TimeoutCycles != 0) && (cnt_inc == TimeoutVal)) begin
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed commands against a small 4-register APB slave model.
// Expected responses are queued at issue time and checked by an independent response monitor.
// Slave wait states/stall, response backpressure and reset mid-transfer are driven from the stimulus block.

module tb_apb_cmd_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    apb_cmd_master_pkg::apb_req_t  apb_req;
    apb_cmd_master_pkg::apb_resp_t apb_resp;

    apb_cmd_master #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(16)
    ) dut (
        .pclk_i       (pclk),
        .preset_i     (preset),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_write_i  (cmd_write),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_strb_i   (cmd_strb),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .apb_req_o    (apb_req),
        .apb_resp_i   (apb_resp)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- slave model: 4 regs at 0x0..0xC, reg 3 read-only ----------------
    logic [31:0] regs [4];
    int          slave_wait;
    bit          slave_stall;
    int          acc_cnt;
    logic        hit;
    logic [1:0]  idx;

    always_comb begin
        apb_resp = '0;
        hit      = (apb_req.paddr[15:0] < 16'h0010);
        idx      = apb_req.paddr[3:2];
        apb_resp.pready = apb_req.psel && apb_req.penable && !slave_stall && (acc_cnt >= slave_wait);
        if (!hit) begin
            apb_resp.prdata  = 32'h0BAD_B10C;
            apb_resp.pslverr = 1'b1;
        end else begin
            apb_resp.prdata  = regs[idx];
            apb_resp.pslverr = apb_req.pwrite && (idx == 2'd3);
        end
    end

    always @(posedge pclk) begin
        if (preset) begin
            acc_cnt <= 0;
            regs[0] <= 32'h0;
            regs[1] <= 32'h0;
            regs[2] <= 32'h0;
            regs[3] <= 32'hC0FF_EE03;
        end else begin
            if (apb_req.psel && apb_req.penable && !apb_resp.pready) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (apb_req.psel && apb_req.penable && apb_resp.pready && apb_req.pwrite && hit && idx != 2'd3) begin
                for (int b = 0; b < 4; b++)
                    if (apb_req.pstrb[b]) regs[idx][8*b +: 8] <= apb_req.pwdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always @(negedge pclk) begin
        if (!preset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b to %0b, expected no response",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata",   rsp_rdata,          e.rdata);
                check("rsp_err",     {31'h0, rsp_err},     {31'h0, e.err});
                check("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.to});
            end
        end
    end

    // Issue one command (called at posedge+1), check SETUP fields, ACCESS count and latency.
    task automatic do_cmd(input logic [31:0] addr, input bit wr, input logic [31:0] wd, input logic [3:0] st,
                          input logic [31:0] er, input bit ee, input bit et, input int exp_acc);
        int cyc;
        int acc;
        exp_q.push_back({er, ee, et});
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(posedge pclk); #1;
            cyc++;
        end
        if (!cmd_ready) check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        // cycle 1: SETUP
        check("setup_psel_penable", {30'h0, apb_req.psel, apb_req.penable}, 32'h2);
        check("setup_paddr",  apb_req.paddr, addr);
        check("setup_pwdata", apb_req.pwdata, wr ? wd : 32'h0);
        check("setup_pstrb",  {28'h0, apb_req.pstrb}, {28'h0, (wr ? st : 4'h0)});
        cyc = 1;
        acc = 0;
        while (!rsp_valid && cyc < 100) begin
            if (apb_req.psel && apb_req.penable) acc++;
            @(posedge pclk); #1;
            cyc++;
        end
        check("access_cycles", acc, exp_acc);
        check("rsp_latency", cyc, exp_acc + 2);
        check("psel_after_done", {31'h0, apb_req.psel}, 32'h0);
        if (rsp_ready) begin
            @(posedge pclk); #1;
            check("cmd_ready_reopen", {31'h0, cmd_ready}, 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        preset      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_write   = 1'b0;
        cmd_wdata   = '0;
        cmd_strb    = '0;
        rsp_ready   = 1'b1;
        slave_wait  = 0;
        slave_stall = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_psel_penable", {30'h0, apb_req.psel, apb_req.penable}, 32'h0);
        check("rst_paddr", apb_req.paddr, 32'h0);
        check("rst_rsp", {29'h0, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        preset = 1'b0;
        #1;
        check("cmd_ready_after_rst", {31'h0, cmd_ready}, 32'h1);

        // write then read back
        do_cmd(32'h1000_0004, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 1);
        do_cmd(32'h1000_0004, 0, 32'h5555_5555, 4'hF, 32'hDEAD_BEEF, 0, 0, 1);
        // partial strobe
        do_cmd(32'h0000_0000, 1, 32'h1234_5678, 4'hF, 32'h0, 0, 0, 1);
        do_cmd(32'h0000_0000, 1, 32'h0000_00AA, 4'h1, 32'h0, 0, 0, 1);
        do_cmd(32'h0000_0000, 0, 32'h0, 4'h0, 32'h1234_56AA, 0, 0, 1);
        // read-only register write and decode miss
        do_cmd(32'h0000_000C, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 1);
        do_cmd(32'h0000_0100, 0, 32'h0, 4'h0, 32'h0BAD_B10C, 1, 0, 1);
        // wait states
        slave_wait = 2;
        do_cmd(32'h0000_0004, 0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 3);
        // stalled slave times out after 16 ACCESS cycles
        slave_stall = 1'b1;
        do_cmd(32'h0000_0004, 0, 32'h0, 4'h0, 32'h0, 1, 1, 16);
        slave_stall = 1'b0;
        // pready on the 16th ACCESS cycle completes normally
        slave_wait = 15;
        do_cmd(32'h0000_0004, 0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 16);
        slave_wait = 0;

        // response backpressure for 5 cycles
        rsp_ready = 1'b0;
        do_cmd(32'h0000_0000, 0, 32'h0, 4'h0, 32'h1234_56AA, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_rdata", rsp_rdata, 32'h1234_56AA);
            check("bp_cmd_ready_psel", {30'h0, cmd_ready, apb_req.psel}, 32'h0);
            @(posedge pclk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        check("bp_cmd_ready_after", {31'h0, cmd_ready}, 32'h1);

        // reset during a stalled ACCESS: transfer dropped, no response
        slave_stall = 1'b1;
        cmd_addr  = 32'h0000_0008;
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("mid_access_psel_penable", {30'h0, apb_req.psel, apb_req.penable}, 32'h3);
        preset = 1'b1;
        @(posedge pclk); #1;
        check("rst_mid_psel_penable", {30'h0, apb_req.psel, apb_req.penable}, 32'h0);
        check("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        preset = 1'b0;
        slave_stall = 1'b0;
        #1;
        check("rst_mid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (5) @(posedge pclk);
        #1;
        check("rst_mid_no_rsp", {31'h0, rsp_valid}, 32'h0);

        // normal operation resumes; slave registers were reset too
        do_cmd(32'h0000_000C, 0, 32'h0, 4'h0, 32'hC0FF_EE03, 0, 0, 1);

        repeat (4) @(posedge pclk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
